spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-byte SPI master supporting all four CPOL/CPHA modes. A transfer is
//   started by i_en while idle. It runs through a one-tick lead-in, sixteen
//   SCLK edges and a one-tick tail. After that the received byte is published
//   on o_data_out and o_done pulses for one cycle. One tick is CLK_DIV system
//   clocks, which is one SCLK half-period.
//
// Parameters
//   CLK_DIV     system-clock cycles per SCLK half-period (2..255)
//
// Ports
//   i_clk       system clock, rising-edge active
//   i_rst       asynchronous active-high reset
//   i_en        start request, only looked at while idle
//   i_cpol      SCLK idle level, latched at transfer start
//   i_cpha      0: sample on leading edge, 1: sample on trailing edge
//   i_data_in   byte to transmit (MSB first), latched at transfer start
//   i_miso      serial data from the slave
//   o_sclk      SPI clock (registered)
//   o_mosi      serial data to the slave (registered)
//   o_ss        slave select, active-low (registered)
//   o_busy      high from transfer accept until completion
//   o_done      one-cycle pulse when o_data_out is updated
//   o_data_out  last received byte
// -----------------------------------------------------------------------------
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_cpol,
   input  logic       i_cpha,
   input  logic [7:0] i_data_in,
   input  logic       i_miso,
   output logic       o_sclk,
   output logic       o_mosi,
   output logic       o_ss,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      XFER  = 2'd2,
      TRAIL = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     r_state;
   state_t     w_state_next;

   logic [7:0] r_div;
   logic [3:0] r_edge_cnt;   // number of SCLK edges already produced (0..15)
   logic [7:0] r_tx_shift;
   logic [7:0] r_rx_shift;
   logic       r_cpol;
   logic       r_cpha;
   logic       r_sclk;
   logic       r_mosi;
   logic       r_ss;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_data_out;

   logic       w_tick;
   logic       w_last_edge;
   logic       w_edge_odd;
   logic       w_sample;
   logic       w_drive;
   logic       w_tx_bit;

   // Tick and per-edge decode for the SCLK edge about to be produced.
   always_comb begin
      w_tick      = (r_div == DIV_LAST);
      w_last_edge = (r_edge_cnt == 4'd15);
      // Edge number is r_edge_cnt+1, so it is odd when the count is even.
      w_edge_odd  = ~r_edge_cnt[0];
      if (r_cpha == 1'b0) begin
         // Bit 7 already went out on LEAD entry, so the even edges carry bits 6..0
         // and edge 16 has nothing left to drive.
         w_sample = w_edge_odd;
         w_drive  = ~w_edge_odd & ~w_last_edge;
         w_tx_bit = r_tx_shift[6];
      end else begin
         w_sample = ~w_edge_odd;
         w_drive  = w_edge_odd;
         w_tx_bit = r_tx_shift[7];
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_en) begin
               w_state_next = LEAD;
            end else begin
               w_state_next = IDLE;
            end
         end
         LEAD: begin
            if (w_tick) begin
               w_state_next = XFER;
            end else begin
               w_state_next = LEAD;
            end
         end
         XFER: begin
            if (w_tick && w_last_edge) begin
               w_state_next = TRAIL;
            end else begin
               w_state_next = XFER;
            end
         end
         TRAIL: begin
            if (w_tick) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = TRAIL;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Divider, shift registers and registered SPI/handshake outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div      <= 8'd0;
         r_edge_cnt <= 4'd0;
         r_tx_shift <= 8'h00;
         r_rx_shift <= 8'h00;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_ss       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_data_out <= 8'h00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // The idle clock level tracks the live input, not the latched one.
               r_sclk     <= i_cpol;
               r_mosi     <= 1'b0;
               r_ss       <= 1'b1;
               r_busy     <= 1'b0;
               r_div      <= 8'd0;
               r_edge_cnt <= 4'd0;
               if (i_en) begin
                  r_tx_shift <= i_data_in;
                  r_rx_shift <= 8'h00;
                  r_cpol     <= i_cpol;
                  r_cpha     <= i_cpha;
                  r_ss       <= 1'b0;
                  r_busy     <= 1'b1;
                  // In mode CPHA=0 the slave samples on the first edge, so the
                  // MSB must already be on the line during the lead-in.
                  r_mosi     <= i_cpha ? 1'b0 : i_data_in[7];
               end else begin
                  r_tx_shift <= r_tx_shift;
               end
            end
            LEAD: begin
               if (w_tick) begin
                  r_div <= 8'd0;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            XFER: begin
               if (w_tick) begin
                  r_div      <= 8'd0;
                  r_sclk     <= ~r_sclk;
                  r_edge_cnt <= r_edge_cnt + 4'd1;
                  if (w_sample) begin
                     r_rx_shift <= {r_rx_shift[6:0], i_miso};
                  end else begin
                     r_rx_shift <= r_rx_shift;
                  end
                  if (w_drive) begin
                     r_mosi     <= w_tx_bit;
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end else begin
                     r_tx_shift <= r_tx_shift;
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            TRAIL: begin
               if (w_tick) begin
                  r_div      <= 8'd0;
                  r_ss       <= 1'b1;
                  r_busy     <= 1'b0;
                  r_mosi     <= 1'b0;
                  r_sclk     <= r_cpol;
                  r_data_out <= r_rx_shift;
                  r_done     <= 1'b1;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: begin
               r_div  <= 8'd0;
               r_ss   <= 1'b1;
               r_busy <= 1'b0;
               r_mosi <= 1'b0;
            end
         endcase
      end
   end

   assign o_sclk     = r_sclk;
   assign o_mosi     = r_mosi;
   assign o_ss       = r_ss;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Self-checking bench for spi_master (CLK_DIV = 4). A behavioural SPI slave
//   reacts to the observed SCLK edges according to CPOL/CPHA. Expected values
//   come from the protocol rules. The slave must receive the transmitted byte.
//   The master must report the slave's byte, finish 18*CLK_DIV cycles after
//   accept, and keep ss low for 18*CLK_DIV cycles.
// -----------------------------------------------------------------------------
module tb_spi_master;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       cpol;
   logic       cpha;
   logic [7:0] data_in;
   logic       miso;
   logic       sclk;
   logic       mosi;
   logic       ss;
   logic       busy;
   logic       done;
   logic [7:0] data_out;

   spi_master #(.CLK_DIV(DIV)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_cpol     (cpol),
      .i_cpha     (cpha),
      .i_data_in  (data_in),
      .i_miso     (miso),
      .o_sclk     (sclk),
      .o_mosi     (mosi),
      .o_ss       (ss),
      .o_busy     (busy),
      .o_done     (done),
      .o_data_out (data_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Slave configuration written by the stimulus thread.
   logic       s_cpol = 1'b0;
   logic       s_cpha = 1'b0;
   logic [7:0] s_tx = 8'h00;
   logic       loopback = 1'b1;

   // State owned by the monitor / slave process.
   int         cyc = 0;
   int         accept_cyc = 0;
   int         done_cyc = 0;
   int         done_cnt = 0;
   int         ss_low_len = 0;
   int         last_ss_low = 0;
   int         ss_high_len = 0;
   int         last_ss_high = 0;
   logic       prev_busy = 1'b0;
   logic       prev_ss = 1'b1;
   logic       prev_sclk = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] last_dout = 8'h00;
   logic [7:0] s_rx = 8'h00;
   int         s_idx = 0;
   logic       s_miso = 1'b0;

   assign miso = loopback ? mosi : s_miso;

   always @(posedge clk) cyc <= cyc + 1;

   // Protocol monitor and behavioural slave, evaluated mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_busy   <= 1'b0;
         prev_ss     <= 1'b1;
         prev_sclk   <= sclk;
         prev_done   <= 1'b0;
         last_dout   <= 8'h00;
         ss_low_len  <= 0;
         ss_high_len <= 0;
         s_rx        <= 8'h00;
         s_miso      <= 1'b0;
      end else begin
         if (busy && !prev_busy) accept_cyc <= cyc;
         if (done) begin
            done_cyc  <= cyc;
            done_cnt  <= done_cnt + 1;
            last_dout <= data_out;
         end else begin
            check_val("dout_hold", {24'd0, data_out}, {24'd0, last_dout});
         end
         if (prev_done) check_val("done_width", {31'd0, done}, 32'd0);
         if (!ss) begin
            ss_low_len <= ss_low_len + 1;
            if (prev_ss) begin
               last_ss_high <= ss_high_len;
               ss_high_len  <= 0;
            end
         end else begin
            ss_high_len <= ss_high_len + 1;
            if (!prev_ss) begin
               last_ss_low <= ss_low_len;
               ss_low_len  <= 0;
            end
         end
         // Slave: sample edge is leading for CPHA=0 and trailing for CPHA=1.
         if (!ss && prev_ss) begin
            s_rx <= 8'h00;
            if (!s_cpha) begin
               s_miso <= s_tx[7];
               s_idx  <= 6;
            end else begin
               s_idx  <= 7;
            end
         end else if (!ss && (sclk != prev_sclk)) begin
            if ((prev_sclk == s_cpol) ^ s_cpha) begin
               s_rx <= {s_rx[6:0], mosi};
            end else begin
               if (s_idx >= 0) s_miso <= s_tx[s_idx[2:0]];
               s_idx <= s_idx - 1;
            end
         end
         prev_busy <= busy;
         prev_ss   <= ss;
         prev_sclk <= sclk;
         prev_done <= done;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check_val("done_timeout", 32'd0, 32'd1);
   endtask

   // One complete transfer; poke > 0 raises en for one cycle mid-transfer with 0xFF.
   task automatic run_xfer(input logic m_cpol, input logic m_cpha, input logic [7:0] data,
                           input logic [7:0] sbyte, input logic lb, input int poke);
      int  d0;
      bit  ok;
      logic [7:0] exp_rx;
      cpol = m_cpol;
      cpha = m_cpha;
      s_cpol = m_cpol;
      s_cpha = m_cpha;
      s_tx = sbyte;
      loopback = lb;
      data_in = data;
      en = 1'b0;
      tick();
      check_val("idle_sclk", {31'd0, sclk}, {31'd0, m_cpol});
      check_val("idle_ss", {31'd0, ss}, 32'd1);
      check_val("idle_mosi", {31'd0, mosi}, 32'd0);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      d0 = done_cnt;
      en = 1'b1;
      tick();
      en = 1'b0;
      check_val("accept_busy", {31'd0, busy}, 32'd1);
      check_val("accept_ss", {31'd0, ss}, 32'd0);
      // Inputs wiggled after accept must not disturb the transfer.
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (poke > 0 && i == poke) begin
            en = 1'b1;
            data_in = 8'hFF;
         end else begin
            en = 1'b0;
         end
         tick();
      end
      en = 1'b0;
      if (!ok) begin
         check_val("done_timeout", 32'd0, 32'd1);
      end else begin
         exp_rx = lb ? data : sbyte;
         check_val("latency", 32'(done_cyc - accept_cyc), 32'(18 * DIV));
         check_val("data_out", {24'd0, data_out}, {24'd0, exp_rx});
         check_val("slave_rx", {24'd0, s_rx}, {24'd0, data});
         check_val("end_sclk", {31'd0, sclk}, {31'd0, m_cpol});
         check_val("end_ss", {31'd0, ss}, 32'd1);
         check_val("end_busy", {31'd0, busy}, 32'd0);
         check_val("ss_low_len", 32'(last_ss_low), 32'(18 * DIV));
         check_val("done_count", 32'(done_cnt), 32'(d0 + 1));
         tick();
         check_val("done_low", {31'd0, done}, 32'd0);
      end
      cpol = m_cpol;
   endtask

   initial begin
      bit ok;
      int t1;
      int d0;
      rst = 1'b1;
      en = 1'b0;
      cpol = 1'b1;
      cpha = 1'b0;
      data_in = 8'h00;
      #2;
      check_val("rst_ss", {31'd0, ss}, 32'd1);
      check_val("rst_sclk", {31'd0, sclk}, 32'd0);
      check_val("rst_mosi", {31'd0, mosi}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_dout", {24'd0, data_out}, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Mode 0 loopback.
      run_xfer(1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
      // Mode 3 with slave returning 0x3C.
      run_xfer(1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0, 0);
      // en pulse with 0xFF in the middle of a transfer is ignored.
      run_xfer(1'b0, 1'b1, 8'h96, 8'h69, 1'b0, 20);

      // Reset at the fifth SCLK edge of a transfer.
      cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; loopback = 1'b1;
      data_in = 8'hE7;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (6 * DIV - 1) tick();
      @(posedge clk);
      #1;
      check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      check_val("abort_ss", {31'd0, ss}, 32'd1);
      check_val("abort_sclk", {31'd0, sclk}, 32'd0);
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_dout", {24'd0, data_out}, 32'd0);
      check_val("abort_done", {31'd0, done}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      check_val("abort_no_done", 32'(done_cnt), 32'(d0));
      run_xfer(1'b0, 1'b0, 8'h5A, 8'h00, 1'b1, 0);

      // Back-to-back with en held high: 0x12 then 0x34.
      cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; loopback = 1'b1;
      data_in = 8'h12;
      tick();
      en = 1'b1;
      tick();
      data_in = 8'h34;
      wait_done(ok);
      t1 = done_cyc;
      if (ok) check_val("b2b_first", {24'd0, data_out}, 32'h12);
      tick();
      en = 1'b0;
      check_val("b2b_restart", {31'd0, busy}, 32'd1);
      wait_done(ok);
      if (ok) begin
         check_val("b2b_second", {24'd0, data_out}, 32'h34);
         check_val("b2b_spacing", 32'(done_cyc - t1), 32'(18 * DIV + 1));
         check_val("b2b_ss_gap", 32'(last_ss_high), 32'd1);
      end
      tick();

      // Randomised transfers.
      for (int k = 0; k < 24; k++) begin
         run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
